fp_mult_result_buffer: RTL and testbench
========================================

FP_MULT_RESULT_BUFFER -- requirements
Module: fp_mult_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of result entries; SHALL be a power of two, 2..16.
REQ-002 Parameter IRQ_MASK, default 6'b011100: selects which sticky flags drive irq; only used with FP_FLAG_IRQ_EN.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  producer (fp_mult result stage) presents a result.
REQ-006 in_z  input  32  IEEE-754 single result z.
REQ-007 in_status  input  8  status byte {0,0,inexact,huge,tiny,nan,inf,zero}.
REQ-008 in_ready  output  1  buffer can accept a result this cycle.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_z  output  32  head result.
REQ-011 out_status  output  8  head status.
REQ-012 out_ready  input  1  consumer takes head entry.
REQ-013 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-014 flags  output  6  sticky exception flags, same bit order as in_status[5:0].
REQ-015 drop_err  output  1  sticky: a result was offered while full.
REQ-016 flag_clr  input  1  clears flags and drop_err.
REQ-017 irq  output  1  present only when FP_FLAG_IRQ_EN is defined.

Function
REQ-018 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-019 in_ready SHALL equal (count < DEPTH), combinationally from registered count; no same-cycle bypass when full.
REQ-020 out_valid SHALL equal (count != 0); out_z/out_status SHALL show the head entry and SHALL be 0 when out_valid=0.
REQ-021 Entries SHALL leave in push order (FIFO); write/read pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 Push into empty buffer: out_valid SHALL rise the following cycle (latency 1); no combinational in->out path.
REQ-023 Simultaneous push and pop: both SHALL take effect, count unchanged; when count=DEPTH, push is blocked (in_ready=0) even if pop occurs.
REQ-024 Count SHALL increment on push-only, decrement on pop-only, never exceed DEPTH nor go below 0.
REQ-025 On push, flags SHALL update to flags | in_status[5:0]; pops SHALL not alter flags.
REQ-026 in_valid && !in_ready SHALL set drop_err next cycle; the offered word SHALL be discarded, FIFO contents unchanged.
REQ-027 flag_clr alone SHALL zero flags and drop_err next cycle.
REQ-028 flag_clr with push same cycle: flags SHALL become in_status[5:0] of the pushed word; flag_clr with drop same cycle: drop_err SHALL become 1.
REQ-029 flag_clr SHALL not affect FIFO contents, pointers or count.

Reset
REQ-030 While rst=1 at a clock edge: pointers, count, flags, drop_err (and irq) SHALL become 0; out_valid=0, in_ready=1 from the next cycle.
REQ-031 Reset SHALL take priority over push, pop and flag_clr; entries present mid-operation SHALL be discarded.
REQ-032 Storage array contents SHALL not require reset.

Configuration
REQ-033 Macro FP_FLAG_IRQ_EN defined: irq SHALL be a register equal to |(flags & IRQ_MASK) | drop_err evaluated on next-state values, i.e. asserting the cycle after the triggering push/drop, deasserting the cycle after flag_clr.
REQ-034 Macro FP_FLAG_IRQ_EN undefined: irq port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-035 Reset, push z=0x40400000 status=0x00, out_ready=0 -> next cycle out_valid=1, out_z=0x40400000, count=1, flags=0.
REQ-036 DEPTH=4: push 5 words back-to-back, out_ready=0 -> in_ready=0 after 4th, 5th dropped, drop_err=1, count=4; drain -> 4 words in order.
REQ-037 count=4, in_valid=1 and out_ready=1 same cycle -> pop only, count=3; next cycle push accepted, count=4.
REQ-038 Push status 0x04 (nan) then 0x20 (inexact) -> flags=6'b100100; flag_clr with push status 0x02 -> flags=6'b000010.
REQ-039 FP_FLAG_IRQ_EN, default mask: push status 0x20 -> irq stays 0; push status 0x08 (tiny) -> irq=1 next cycle; flag_clr -> irq=0 next cycle.
REQ-040 rst asserted with count=3 -> next cycle count=0, out_valid=0, out_z=0, flags=0.

Source files
------------

// File: rtl/fp_mult_result_buffer.sv
// fp_mult_result_buffer: DEPTH-entry FIFO of fp_mult results {z, status} with sticky exception and drop flags.
// Latency: push to out_valid is 1 cycle, with no combinational in->out path. Optional irq under `FP_FLAG_IRQ_EN.
// Backpressure: in_ready = count < DEPTH, with no same-cycle bypass when full. Words offered while full are dropped and flagged.
module fp_mult_result_buffer #(
    parameter int         DEPTH    = 4,
    parameter logic [5:0] IRQ_MASK = 6'b011100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_z,
    input  logic [7:0]                 in_status,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_z,
    output logic [7:0]                 out_status,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [5:0]                 flags,
    output logic                       drop_err,
    input  logic                       flag_clr
`ifdef FP_FLAG_IRQ_EN
    ,
    output logic                       irq
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] z;
        logic [7:0]  status;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;
    logic [5:0]    flags_nxt;
    logic          drop_nxt;
    logic          unused_sig;

    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign drop      = in_valid & ~in_ready;

    // Output lines are forced to zero while the buffer is empty, so the stale head entry is not visible.
    assign head       = out_valid ? mem[rd_ptr] : '0;
    assign out_z      = head.z;
    assign out_status = head.status;

    // Reserved status bits are not stored in the flags, and the mask only matters when irq is built.
    assign unused_sig = ^{in_status[7:6], IRQ_MASK};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_z, in_status};
        end
    end

    // The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A clear coinciding with a push or drop still records that event.
    always_comb begin
        flags_nxt = flag_clr ? 6'b0 : flags;
        if (push) begin
            flags_nxt = flags_nxt | in_status[5:0];
        end
        drop_nxt = (flag_clr ? 1'b0 : drop_err) | drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags    <= '0;
            drop_err <= 1'b0;
        end else begin
            flags    <= flags_nxt;
            drop_err <= drop_nxt;
        end
    end

`ifdef FP_FLAG_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (|(flags_nxt & IRQ_MASK)) | drop_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mult_result_buffer.sv
// Bench for fp_mult_result_buffer: directed scenarios then random traffic against a queue-based reference model.
module tb_fp_mult_result_buffer;
    localparam int         DEPTH = 4;
    localparam logic [5:0] MASK  = 6'b011100;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_z;
    logic [7:0]  in_status;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_z;
    logic [7:0]  out_status;
    logic        out_ready;
    logic [2:0]  count;
    logic [5:0]  flags;
    logic        drop_err;
    logic        flag_clr;
`ifdef FP_FLAG_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    fp_mult_result_buffer #(.DEPTH(DEPTH), .IRQ_MASK(MASK)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_z       (in_z),
        .in_status  (in_status),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_z      (out_z),
        .out_status (out_status),
        .out_ready  (out_ready),
        .count      (count),
        .flags      (flags),
        .drop_err   (drop_err),
        .flag_clr   (flag_clr)
`ifdef FP_FLAG_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    typedef struct packed {
        logic [31:0] z;
        logic [7:0]  st;
    } ent_t;

    ent_t        q[$];
    logic [5:0]  m_flags;
    logic        m_drop;
    int          tests = 0;
    int          errs  = 0;
    logic [31:0] words [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ez;
        logic [7:0]  es;
        ez = (q.size() != 0) ? q[0].z : 32'h0;
        es = (q.size() != 0) ? q[0].st : 8'h0;
        chk({tag, "/count"}, 32'(count), 32'(q.size()));
        chk({tag, "/out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, "/in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
        chk({tag, "/out_z"}, out_z, ez);
        chk({tag, "/out_status"}, 32'(out_status), 32'(es));
        chk({tag, "/flags"}, 32'(flags), 32'(m_flags));
        chk({tag, "/drop_err"}, 32'(drop_err), 32'(m_drop));
`ifdef FP_FLAG_IRQ_EN
        chk({tag, "/irq"}, 32'(irq), 32'((|(m_flags & MASK)) | m_drop));
`endif
    endtask

    // One clock: drive the inputs, advance the model, then sample 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [31:0] z, input logic [7:0] st,
                       input logic ordy, input logic clr);
        bit acc;
        bit take;
        in_valid  = v;
        in_z      = z;
        in_status = st;
        out_ready = ordy;
        flag_clr  = clr;
        acc  = v && (q.size() < DEPTH);
        take = ordy && (q.size() != 0);
        if (clr) begin
            m_flags = '0;
            m_drop  = 1'b0;
        end
        if (take) void'(q.pop_front());
        if (acc) begin
            q.push_back({z, st});
            m_flags = m_flags | st[5:0];
        end else if (v) begin
            m_drop = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flag_clr  = 1'b0;
    endtask

    // Reset is held while other inputs are active, to show that reset wins.
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_z      = 32'hdeadbeef;
        in_status = 8'h3f;
        out_ready = 1'b1;
        flag_clr  = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flag_clr  = 1'b0;
        q.delete();
        m_flags = '0;
        m_drop  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_z = '0; in_status = '0; out_ready = 1'b0; flag_clr = 1'b0;
        m_flags = '0; m_drop = 1'b0;
        do_reset();
        check_all("reset");

        cyc(1, 32'h40400000, 8'h00, 0, 0);
        chk("first_push_out_valid", 32'(out_valid), 32'd1);
        chk("first_push_out_z", out_z, 32'h40400000);
        chk("first_push_count", 32'(count), 32'd1);
        check_all("first_push");

        do_reset();
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        for (int i = 0; i < 5; i++) begin
            cyc(1, words[i], 8'h00, 0, 0);
            check_all("fill");
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_drop_err", 32'(drop_err), 32'd1);
        chk("full_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", out_z, words[i]);
            cyc(0, 32'h0, 8'h00, 1, 0);
            check_all("drain");
        end
        chk("drained_out_z", out_z, 32'h0);

        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, $urandom, 8'h00, 0, 0);
        cyc(1, 32'h3f800000, 8'h00, 1, 0);
        chk("full_pushpop_count", 32'(count), 32'd3);
        check_all("full_pushpop");
        cyc(1, 32'h3f800000, 8'h00, 0, 0);
        chk("refill_count", 32'(count), 32'd4);
        check_all("refill");

        do_reset();
        cyc(1, 32'h7fc00000, 8'h04, 0, 0);
        cyc(1, 32'h3eaaaaab, 8'h20, 0, 0);
        chk("flags_or", 32'(flags), 32'(6'b100100));
        cyc(1, 32'h7f800000, 8'h02, 0, 1);
        chk("flags_clr_push", 32'(flags), 32'(6'b000010));
        check_all("clr_push");
        cyc(0, 32'h0, 8'h00, 0, 1);
        chk("flags_clr_alone", 32'(flags), 32'd0);
        check_all("clr_alone");

`ifdef FP_FLAG_IRQ_EN
        do_reset();
        cyc(1, 32'h3f800001, 8'h20, 0, 0);
        chk("irq_inexact", 32'(irq), 32'd0);
        cyc(1, 32'h00000001, 8'h08, 0, 0);
        chk("irq_tiny", 32'(irq), 32'd1);
        cyc(0, 32'h0, 8'h00, 0, 1);
        chk("irq_clr", 32'(irq), 32'd0);
`endif

        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, $urandom, 8'h3f, 0, 0);
        chk("pre_reset_count", 32'(count), 32'd3);
        do_reset();
        chk("mid_reset_count", 32'(count), 32'd0);
        chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_out_z", out_z, 32'h0);
        chk("mid_reset_flags", 32'(flags), 32'd0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(63) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(3) != 0), $urandom, 8'($urandom),
                    $urandom_range(1) == 1, ($urandom_range(15) == 0));
            end
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
